// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_DEFAULT_BASE = 32'h0000_0400;
    localparam int          DMEM_LAT_W        = 4;

    // Operands of one access, captured at accept time.
    typedef struct packed {
        logic        write;
        logic        byte_acc;
        logic [1:0]  lane;
        logic        in_win;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with synchronous byte-enabled write and combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int WORDS = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // NOTE: the storage array has no reset so it maps onto RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: address window, programmable latency, ready stall.
// Optional byte-lane access (LDRB/STRB) is enabled by defining DMEM_BYTE_LANE_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          WORDS     = 64,
    parameter logic [31:0] BASE_ADDR = DMEM_DEFAULT_BASE,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
`ifdef DMEM_BYTE_LANE_EN
    input  logic        byte_access,
`endif
    output logic [31:0] rdata,
    output logic        ready,
    output logic        addr_err
);

    localparam int AW = $clog2(WORDS);

    dmem_state_t           state, state_nx;
    logic [DMEM_LAT_W-1:0] cnt;
    dmem_req_t             req_live, req_q, req_cur;
    logic [AW-1:0]         idx_live, idx_q, idx_cur;
    logic [31:0]           diff, arr_rdata, arr_wdata, rd_word, rdata_q;
    logic [7:0]            rd_byte;
    logic [3:0]            arr_be;
    logic                  request, commit, arr_we, addr_err_q, byte_in;

`ifdef DMEM_BYTE_LANE_EN
    assign byte_in = byte_access;
`else
    assign byte_in = 1'b0;
`endif

    assign request = mem_read | mem_write;

    // Full 32-bit difference is compared so addresses far above the window never alias.
    always_comb begin
        diff     = address - BASE_ADDR;
        idx_live = diff[AW+1:2];
        req_live = '{write:    mem_write,
                     byte_acc: byte_in,
                     lane:     address[1:0],
                     in_win:   (address >= BASE_ADDR) && ((diff >> 2) < 32'(WORDS)),
                     wdata:    wdata};
    end

    // With LATENCY 0 the commit happens on the accept edge, so live inputs are used in IDLE.
    assign req_cur = (state == IDLE) ? req_live : req_q;
    assign idx_cur = (state == IDLE) ? idx_live : idx_q;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nx = state;
        ready    = 1'b1;
        case (state)
            IDLE: begin
                ready = !request;
                if (request) state_nx = (LATENCY > 0) ? WAIT : DONE;
            end
            WAIT: begin
                ready = 1'b0;
                if (cnt <= DMEM_LAT_W'(1)) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign commit = (state != DONE) && (state_nx == DONE);

    always_comb begin
        arr_we    = commit && req_cur.write && req_cur.in_win && !rst;
        arr_be    = req_cur.byte_acc ? lane_mask(req_cur.lane) : 4'hF;
        arr_wdata = req_cur.byte_acc ? {4{req_cur.wdata[7:0]}} : req_cur.wdata;
        rd_byte   = arr_rdata[{req_cur.lane, 3'b000} +: 8];
        rd_word   = req_cur.byte_acc ? {24'h0, rd_byte} : arr_rdata;
    end

    dmem_array #(.WORDS(WORDS), .AW(AW)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (idx_cur),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && request) cnt <= DMEM_LAT_W'(LATENCY);
            else if (state == WAIT)       cnt <= cnt - 1'b1;

            if (commit) begin
                rdata_q    <= (!req_cur.write && req_cur.in_win) ? rd_word : '0;
                addr_err_q <= !req_cur.in_win;
            end else if (state == DONE) begin
                rdata_q    <= '0;
                addr_err_q <= 1'b0;
            end
        end
    end

    // Captured request operands are pure data qualified by the FSM, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && request) begin
            req_q <= req_live;
            idx_q <= idx_live;
        end
    end

    assign rdata    = rdata_q;
    assign addr_err = addr_err_q;

endmodule
